// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control decoder: opcode classes, funct7 patterns and select codes.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_LDST   = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_RTYPE  = 3'b010;
  localparam logic [2:0] OP_ITYPE  = 3'b011;
  localparam logic [2:0] OP_LUI    = 3'b100;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam int unsigned CODE_W = 5;

  localparam logic [CODE_W-1:0] SEL_ADD    = 5'd0;
  localparam logic [CODE_W-1:0] SEL_SUB    = 5'd1;
  localparam logic [CODE_W-1:0] SEL_SLL    = 5'd2;
  localparam logic [CODE_W-1:0] SEL_SLT    = 5'd3;
  localparam logic [CODE_W-1:0] SEL_SLTU   = 5'd4;
  localparam logic [CODE_W-1:0] SEL_XOR    = 5'd5;
  localparam logic [CODE_W-1:0] SEL_SRL    = 5'd6;
  localparam logic [CODE_W-1:0] SEL_SRA    = 5'd7;
  localparam logic [CODE_W-1:0] SEL_OR     = 5'd8;
  localparam logic [CODE_W-1:0] SEL_AND    = 5'd9;
  localparam logic [CODE_W-1:0] SEL_PASS_B = 5'd10;
  // M-extension codes occupy 16..23 in funct3 order, so MUL | funct3 yields the op.
  localparam logic [CODE_W-1:0] SEL_MUL    = 5'd16;

  function automatic logic [CODE_W-1:0] base_sel(input logic [2:0] f3);
    logic [CODE_W-1:0] s;
    case (f3)
      3'b000:  s = SEL_ADD;
      3'b001:  s = SEL_SLL;
      3'b010:  s = SEL_SLT;
      3'b011:  s = SEL_SLTU;
      3'b100:  s = SEL_XOR;
      3'b101:  s = SEL_SRL;
      3'b110:  s = SEL_OR;
      default: s = SEL_AND;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_ctrl_pipe_if.sv
// Decode request / ALU select result handshake bundle between decode and execute.
interface alu_ctrl_pipe_if #(
  parameter int unsigned SEL_W = 5,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [9:0]       func_field;
  logic [2:0]       ALUOp;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] ALU_SEL;
  logic             illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, func_field, ALUOp, in_tag, out_ready,
    input  in_ready, out_valid, ALU_SEL, illegal, out_tag
  );

  modport slave (
    input  in_valid, func_field, ALUOp, in_tag, out_ready,
    output in_ready, out_valid, ALU_SEL, illegal, out_tag
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational RISC-V ALU control decoder: {ALUOp, funct7, funct3} -> {select, illegal}.
// M-extension decode is enabled by defining ALU_CTRL_MULDIV_EN.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned SEL_W = 5
) (
  input  logic [2:0]       i_alu_op,
  input  logic [9:0]       i_func_field,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_illegal
);

  logic [6:0]        w_f7;
  logic [2:0]        w_f3;
  logic [CODE_W-1:0] w_code;
  logic              w_illegal;

  assign w_f7 = i_func_field[9:3];
  assign w_f3 = i_func_field[2:0];

  always_comb begin
    w_code    = SEL_ADD;
    w_illegal = 1'b0;
    case (i_alu_op)
      OP_LDST: w_code = SEL_ADD;
      OP_BRANCH: begin
        case (w_f3[2:1])
          2'b00:   w_code = SEL_SUB;
          2'b10:   w_code = SEL_SLT;
          2'b11:   w_code = SEL_SLTU;
          default: w_illegal = 1'b1;
        endcase
      end
      OP_RTYPE: begin
        if (w_f7 == F7_BASE) begin
          w_code = base_sel(w_f3);
        end else if (w_f7 == F7_ALT) begin
          if (w_f3 == 3'b000)      w_code = SEL_SUB;
          else if (w_f3 == 3'b101) w_code = SEL_SRA;
          else                     w_illegal = 1'b1;
        end
`ifdef ALU_CTRL_MULDIV_EN
        else if (w_f7 == F7_MULDIV) begin
          w_code = SEL_MUL | {2'b00, w_f3};
        end
`endif
        else begin
          w_illegal = 1'b1;
        end
      end
      OP_ITYPE: begin
        // funct7 only qualifies the shift-immediate forms.
        case (w_f3)
          3'b001: begin
            if (w_f7 == F7_BASE) w_code = SEL_SLL;
            else                 w_illegal = 1'b1;
          end
          3'b101: begin
            if (w_f7 == F7_BASE)     w_code = SEL_SRL;
            else if (w_f7 == F7_ALT) w_code = SEL_SRA;
            else                     w_illegal = 1'b1;
          end
          default: w_code = base_sel(w_f3);
        endcase
      end
      OP_LUI:  w_code = SEL_PASS_B;
      default: w_illegal = 1'b1;
    endcase
  end

  assign o_sel     = w_illegal ? '0 : SEL_W'(w_code);
  assign o_illegal = w_illegal;

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control stage: decoder behind an output register plus one skid entry,
// with a saturating illegal-op counter. M-extension decode via ALU_CTRL_MULDIV_EN.
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned SEL_W = 5,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_ctrl_pipe_if.slave   bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [SEL_W-1:0] w_dec_sel;
  logic             w_dec_illegal;
  logic             w_accept;
  logic             w_drain;

  logic             r_out_valid;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_out_ill;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_skid_valid;
  logic [SEL_W-1:0] r_skid_sel;
  logic             r_skid_ill;
  logic [TAG_W-1:0] r_skid_tag;
  logic [CNT_W-1:0] r_cnt;

  alu_ctrl_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .i_alu_op     (bus.ALUOp),
    .i_func_field (bus.func_field),
    .o_sel        (w_dec_sel),
    .o_illegal    (w_dec_illegal)
  );

  // in_ready is just !skid_full, so it is a flop output with no path from out_ready.
  assign w_accept = bus.in_valid & ~r_skid_valid;
  assign w_drain  = r_out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_sel    <= '0;
      r_out_ill    <= 1'b0;
      r_out_tag    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_sel   <= '0;
      r_skid_ill   <= 1'b0;
      r_skid_tag   <= '0;
    end else if (!r_out_valid || w_drain) begin
      // Output slot free this cycle; the skid entry is older, so it goes first.
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_sel    <= r_skid_sel;
        r_out_ill    <= r_skid_ill;
        r_out_tag    <= r_skid_tag;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_sel   <= w_dec_sel;
        r_out_ill   <= w_dec_illegal;
        r_out_tag   <= bus.in_tag;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_sel   <= w_dec_sel;
      r_skid_ill   <= w_dec_illegal;
      r_skid_tag   <= bus.in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_cnt <= '0;
    end else if (w_accept && w_dec_illegal && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = ~r_skid_valid;
  assign bus.out_valid = r_out_valid;
  assign bus.ALU_SEL   = r_out_sel;
  assign bus.illegal   = r_out_ill;
  assign bus.out_tag   = r_out_tag;
  assign illegal_cnt   = r_cnt;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Scoreboard bench for alu_ctrl_pipe: directed plan items plus randomized traffic.
module tb_alu_ctrl_pipe;
  localparam int SEL_W = 5;
  localparam int TAG_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cnt_clr;
  logic [CNT_W-1:0] illegal_cnt;

  alu_ctrl_pipe_if #(.SEL_W(SEL_W), .TAG_W(TAG_W)) bus ();

  alu_ctrl_pipe #(
    .SEL_W (SEL_W),
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .cnt_clr     (cnt_clr),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]       sel;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  int   tag_log[$];
  int   model_cnt = 0;
  logic stall_prev = 1'b0;
  logic [SEL_W+TAG_W:0] held = '0;
  bit   rnd_done;

  // Reference: returns the ALU op number, or -1 for an illegal encoding.
  function automatic int ref_code(logic [2:0] op, logic [9:0] ff);
    int f7, f3;
    int r_tab[8];
    int b_tab[8];
    r_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    b_tab = '{1, 1, -1, -1, 3, 3, 4, 4};
    f7 = int'(ff[9:3]);
    f3 = int'(ff[2:0]);
    case (op)
      3'd0: return 0;
      3'd1: return b_tab[f3];
      3'd2: begin
        if (f7 == 0) return r_tab[f3];
        if (f7 == 32) return (f3 == 0) ? 1 : (f3 == 5) ? 7 : -1;
`ifdef ALU_CTRL_MULDIV_EN
        if (f7 == 1) return 16 + f3;
`endif
        return -1;
      end
      3'd3: begin
        if (f3 == 1) return (f7 == 0) ? 2 : -1;
        if (f3 == 5) return (f7 == 0) ? 6 : (f7 == 32) ? 7 : -1;
        return r_tab[f3];
      end
      3'd4: return 10;
      default: return -1;
    endcase
  endfunction

  function automatic exp_t mk_exp(logic [2:0] op, logic [9:0] ff, logic [TAG_W-1:0] tag);
    exp_t r;
    int   c;
    c     = ref_code(op, ff);
    r.sel = (c < 0) ? 5'd0 : 5'(c);
    r.ill = (c < 0);
    r.tag = tag;
    return r;
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected responses are queued at the accepting edge.
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      model_cnt <= 0;
    end else begin
      if (bus.in_valid && bus.in_ready) sb.push_back(mk_exp(bus.ALUOp, bus.func_field, bus.in_tag));
      if (cnt_clr) model_cnt <= 0;
      else if (bus.in_valid && bus.in_ready && ref_code(bus.ALUOp, bus.func_field) < 0 &&
               model_cnt < 255)
        model_cnt <= model_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("illegal_cnt", int'(illegal_cnt), model_cnt);
      if (stall_prev && bus.out_valid)
        check("stall_hold", int'({bus.ALU_SEL, bus.illegal, bus.out_tag}), int'(held));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_output: got tag %0d, expected no output", bus.out_tag);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("alu_sel", int'(bus.ALU_SEL), int'(e.sel));
          check("illegal", int'(bus.illegal), int'(e.ill));
          check("out_tag", int'(bus.out_tag), int'(e.tag));
        end
        tag_log.push_back(int'(bus.out_tag));
      end
    end
    stall_prev <= !rst && bus.out_valid && !bus.out_ready;
    held       <= {bus.ALU_SEL, bus.illegal, bus.out_tag};
  end

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic send(logic [2:0] op, logic [9:0] ff, logic [TAG_W-1:0] tag, bit clr = 1'b0);
    int waited;
    waited         = 0;
    bus.in_valid   = 1'b1;
    bus.ALUOp      = op;
    bus.func_field = ff;
    bus.in_tag     = tag;
    cnt_clr        = clr;
    @(negedge clk);
    while (!bus.in_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0d, expected 1 within 500 cycles", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cnt_clr      = 1'b0;
  endtask

  // With out_ready high and no backlog, the accepted op is in the output register right after.
  task automatic send_chk(string name, logic [2:0] op, logic [9:0] ff, logic [TAG_W-1:0] tag,
                          int exp_sel, int exp_ill);
    send(op, ff, tag);
    check({name, "_valid"}, int'(bus.out_valid), 1);
    check({name, "_sel"}, int'(bus.ALU_SEL), exp_sel);
    check({name, "_ill"}, int'(bus.illegal), exp_ill);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] f7;
    rst            = 1'b1;
    cnt_clr        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.ALUOp      = 3'd0;
    bus.func_field = '0;
    bus.in_tag     = '0;
    bus.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_alu_sel", int'(bus.ALU_SEL), 0);
    check("rst_illegal", int'(bus.illegal), 0);
    check("rst_out_tag", int'(bus.out_tag), 0);
    check("rst_cnt", int'(illegal_cnt), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send_chk("r_sub", 3'b010, {7'b0100000, 3'b000}, 4'd1, 1, 0);
    send_chk("r_and", 3'b010, {7'b0000000, 3'b111}, 4'd2, 9, 0);
    send_chk("r_or", 3'b010, {7'b0000000, 3'b110}, 4'd3, 8, 0);
    send_chk("br_sltu", 3'b001, {7'b1010101, 3'b110}, 4'd4, 4, 0);
    send_chk("br_ill", 3'b001, {7'b0000000, 3'b010}, 4'd5, 0, 1);
    check("cnt_first", int'(illegal_cnt), 1);
    send_chk("i_srai", 3'b011, {7'b0100000, 3'b101}, 4'd6, 7, 0);
    send_chk("i_addi", 3'b011, {7'b0100000, 3'b000}, 4'd7, 0, 0);
    send_chk("lui", 3'b100, 10'h3ff, 4'd8, 10, 0);
    send_chk("ldst", 3'b000, 10'h2a5, 4'd9, 0, 0);
`ifdef ALU_CTRL_MULDIV_EN
    send_chk("muldiv", 3'b010, {7'b0000001, 3'b100}, 4'd10, 20, 0);
`else
    send_chk("muldiv", 3'b010, {7'b0000001, 3'b100}, 4'd10, 0, 1);
`endif
    repeat (2) @(posedge clk);
    #1;

    // Back-pressure: two entries fit, the third must wait.
    tag_log.delete();
    bus.out_ready = 1'b0;
    send(3'b010, {7'b0100000, 3'b000}, 4'd1);
    send(3'b010, {7'b0000000, 3'b111}, 4'd2);
    check("full_in_ready", int'(bus.in_ready), 0);
    fork
      send(3'b010, {7'b0000000, 3'b110}, 4'd3);
      begin
        repeat (4) begin
          @(negedge clk);
          check("stall_in_ready", int'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("stall_drained", tag_log.size(), 3);
    if (tag_log.size() == 3) begin
      check("order_0", tag_log[0], 1);
      check("order_1", tag_log[1], 2);
      check("order_2", tag_log[2], 3);
    end

    // Randomized traffic with random back-pressure.
    rnd_done = 1'b0;
    fork
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        bus.out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 200; i++) begin
          case ($urandom_range(0, 3))
            0:       f7 = 7'b0000000;
            1:       f7 = 7'b0100000;
            2:       f7 = 7'b0000001;
            default: f7 = 7'($urandom);
          endcase
          send(3'($urandom_range(0, 7)), {f7, 3'($urandom)}, 4'($urandom),
               ($urandom_range(0, 15) == 0));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Saturation and clear-beats-increment.
    for (int i = 0; i < 300; i++) send(3'b111, 10'($urandom), 4'($urandom));
    check("cnt_sat", int'(illegal_cnt), 255);
    send(3'b111, 10'h000, 4'd0, 1'b1);
    check("cnt_clr", int'(illegal_cnt), 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset with entries in flight discards them.
    bus.out_ready = 1'b0;
    send(3'b010, 10'h000, 4'd11);
    send(3'b010, 10'h001, 4'd12);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    check("midrst_alu_sel", int'(bus.ALU_SEL), 0);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
- Registered, parametrised successor to the combinational RISC-V ALU control decoder.
- Decodes {funct7, funct3} and a widened ALU opcode class into an ALU select code behind a valid/ready pipeline stage with a 2-entry skid buffer.
- Flags illegal encodings and keeps a saturating illegal-op count.
- Sits between instruction decode and the execute-stage ALU.

Parameters:
- SEL_W, 5, ALU select width; must be ≥5 when MULDIV_EN is defined, ≥4 otherwise.
- TAG_W, 4, width of the opaque tag carried alongside each decode (ROB/PC index).
- CNT_W, 8, width of the illegal-op counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input decode request valid
- in_ready  out  1  stage can accept input
- func_field  in  10  {funct7[6:0], funct3[2:0]}
- ALUOp  in  3  class: 000 LD/ST, 001 BRANCH, 010 R-type, 011 I-type arith, 100 LUI; others are illegal
- in_tag  in  TAG_W  passthrough tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- ALU_SEL  out  SEL_W  ALU operation select
- illegal  out  1  current result came from an illegal encoding
- out_tag  out  TAG_W  tag matching ALU_SEL
- cnt_clr  in  1  clear illegal counter
- illegal_cnt  out  CNT_W  saturating count of accepted illegal ops

Behaviour:
- Select codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10. With MULDIV_EN: MUL 16, MULH 17, MULHSU 18, MULHU 19, DIV 20, DIVU 21, REM 22, REMU 23.
- LD/ST: ADD; func_field ignored.
- BRANCH, by funct3:
  - 000/001 → SUB
  - 100/101 → SLT
  - 110/111 → SLTU
  - 010/011 → illegal
- R-type, by funct7:
  - 0000000 → the funct3 table (000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND).
  - 0100000 → funct3 000 SUB, 101 SRA; other funct3 values illegal.
  - Any other funct7 is illegal.
- I-type:
  - funct7 is ignored except for shifts.
  - funct3 001 requires funct7=0000000 (SLL).
  - funct3 101: funct7 0000000 → SRL, 0100000 → SRA; others illegal.
  - funct3 000 → ADD. There is no SUBI.
- LUI: PASS_B.
- Illegal result: ALU_SEL=0 (ADD) and illegal=1.
- Handshake:
  - Input transfer occurs when in_valid & in_ready; output transfer when out_valid & out_ready.
  - Latency is 1 cycle: the result is registered and appears the cycle after acceptance.
  - Output register plus one skid entry gives 2 entries. in_ready = !skid_full, registered (no combinational path from out_ready).
  - Stalled output holds ALU_SEL/illegal/out_tag stable while out_valid=1 and out_ready=0.
  - Full (output + skid occupied) → in_ready=0. On the cycle the output drains, the skid moves to the output and in_ready rises the next cycle.
  - Simultaneous accept and drain with skid empty: the new result loads directly into the output; out_valid stays 1.
  - Ordering is strictly FIFO.
- Counter:
  - Increments on each accepted illegal input, counted at acceptance and not at output.
  - Saturates at all-ones.
  - cnt_clr sets it to 0; clr wins over a same-cycle increment.
- Reset:
  - out_valid=0, in_ready=1, skid empty, ALU_SEL=0, illegal=0, out_tag=0, illegal_cnt=0.
  - Reset mid-transfer discards all in-flight entries.

Optional Feature:
- ALU_CTRL_MULDIV_EN
- Defined: R-type funct7=0000001 decodes funct3 0..7 → codes 16..23.
- Undefined: funct7=0000001 is illegal, and codes ≥16 are never produced.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALUOp class constants
  - funct7 constants (F7_BASE, F7_ALT, F7_MULDIV)
  - ALU select code constants
- Sub-module alu_ctrl_dec: the pure combinational decoder, {ALUOp, func_field} → {sel, illegal}. It is reused by the pipeline wrapper.

Test Plan:
- After reset: ALUOp=010, func_field=0100000_000, valid → next cycle out_valid=1, ALU_SEL=1, illegal=0. Then func_field=0000000_111 → ALU_SEL=9. Then funct3=110 → ALU_SEL=8.
- ALUOp=001, funct3=110 → 4; funct3=010 → ALU_SEL=0, illegal=1, illegal_cnt=1.
- ALUOp=011, func_field=0100000_101 → 7; same with funct3=000 → 0 (ADD, legal).
- Hold out_ready=0 and push 3 tagged ops (tags 1,2,3):
  - in_ready drops after 2 accepted.
  - Outputs stay stable while stalled.
  - Release → tags emerge 1,2,3 with no loss or duplicate.
- Feed 300 illegal ops (ALUOp=111) with CNT_W=8 → illegal_cnt=255. Then cnt_clr together with an illegal accept → 0.
- With ALU_CTRL_MULDIV_EN: func_field=0000001_100, ALUOp=010 → 20. Without it → illegal=1.
